// File: rtl/add_reservation_station_pkg.sv
// Shared definitions for the add reservation station: default widths, the reserved
// "no producer" tag and the per-entry state encoding.
package add_reservation_station_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefTagW  = 3;
  localparam int unsigned TAG_NONE = 0;

  typedef enum logic [1:0] {
    StFree  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2,
    StExec  = 2'd3
  } rs_state_e;

endpackage

// File: rtl/add_reservation_station_if.sv
// Issue / CDB / dispatch bundle of the add reservation station. The master side
// issues ops, drives the CDB and the adder status; the slave is the station itself.
interface add_reservation_station_if
  import add_reservation_station_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned TAG_W  = DefTagW
);
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_v1;
  logic              issue_v2;
  logic [DATA_W-1:0] issue_d1;
  logic [DATA_W-1:0] issue_d2;
  logic [TAG_W-1:0]  issue_q1;
  logic [TAG_W-1:0]  issue_q2;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              adder_ready;
  logic              disp_valid;
  logic [TAG_W-1:0]  disp_tag;
  logic [DATA_W-1:0] disp_op1;
  logic [DATA_W-1:0] disp_op2;
  logic [2:0]        busy_cnt;

  modport master (
    output issue_valid, issue_v1, issue_v2, issue_d1, issue_d2, issue_q1, issue_q2,
    output cdb_valid, cdb_tag, cdb_data, adder_ready,
    input  issue_ready, issue_tag, disp_valid, disp_tag, disp_op1, disp_op2, busy_cnt
  );

  modport slave (
    input  issue_valid, issue_v1, issue_v2, issue_d1, issue_d2, issue_q1, issue_q2,
    input  cdb_valid, cdb_tag, cdb_data, adder_ready,
    output issue_ready, issue_tag, disp_valid, disp_tag, disp_op1, disp_op2, busy_cnt
  );
endinterface

// File: rtl/add_reservation_station_rs_entry.sv
// One reservation-station slot: lifecycle FSM, two operand value/tag/flag triples and
// CDB capture, both at issue (bypass) and while waiting (snoop).
module add_reservation_station_rs_entry
  import add_reservation_station_pkg::*;
#(
  parameter int unsigned      DATA_W  = DefDataW,
  parameter int unsigned      TAG_W   = DefTagW,
  parameter logic [TAG_W-1:0] OWN_TAG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_i,
  input  logic              disp_i,
  input  logic              issue_v1_i,
  input  logic              issue_v2_i,
  input  logic [DATA_W-1:0] issue_d1_i,
  input  logic [DATA_W-1:0] issue_d2_i,
  input  logic [TAG_W-1:0]  issue_q1_i,
  input  logic [TAG_W-1:0]  issue_q2_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              is_free_o,
  output logic              is_ready_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o
);
  localparam logic [TAG_W-1:0] NoTag = TAG_W'(TAG_NONE);

  rs_state_e         state_q, state_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [TAG_W-1:0]  q1_q, q1_d, q2_q, q2_d;

  logic iss_hit1, iss_hit2, snp_hit1, snp_hit2, own_hit;

  assign iss_hit1 = cdb_valid_i && !issue_v1_i && issue_q1_i != NoTag && cdb_tag_i == issue_q1_i;
  assign iss_hit2 = cdb_valid_i && !issue_v2_i && issue_q2_i != NoTag && cdb_tag_i == issue_q2_i;
  assign snp_hit1 = cdb_valid_i && !v1_q && q1_q != NoTag && cdb_tag_i == q1_q;
  assign snp_hit2 = cdb_valid_i && !v2_q && q2_q != NoTag && cdb_tag_i == q2_q;
  assign own_hit  = cdb_valid_i && cdb_tag_i == OWN_TAG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFree;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
    end
  end

  // Operand datapath: issue (with same-cycle CDB bypass), snoop while waiting, clear on free.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    d1_d = d1_q;
    d2_d = d2_q;
    q1_d = q1_q;
    q2_d = q2_q;
    if (alloc_i) begin
      v1_d = issue_v1_i || iss_hit1;
      v2_d = issue_v2_i || iss_hit2;
      d1_d = issue_v1_i ? issue_d1_i : (iss_hit1 ? cdb_data_i : '0);
      d2_d = issue_v2_i ? issue_d2_i : (iss_hit2 ? cdb_data_i : '0);
      q1_d = issue_v1_i ? NoTag : issue_q1_i;
      q2_d = issue_v2_i ? NoTag : issue_q2_i;
    end else if (state_q == StWait) begin
      if (snp_hit1) begin
        v1_d = 1'b1;
        d1_d = cdb_data_i;
      end
      if (snp_hit2) begin
        v2_d = 1'b1;
        d2_d = cdb_data_i;
      end
    end else if (state_q == StExec && own_hit) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFree:  if (alloc_i) state_d = (v1_d && v2_d) ? StReady : StWait;
      StWait:  if (v1_d && v2_d) state_d = StReady;
      StReady: if (disp_i) state_d = StExec;
      StExec:  if (own_hit) state_d = StFree;
      default: state_d = StFree;
    endcase
  end

  always_comb begin
    is_free_o  = (state_q == StFree);
    is_ready_o = (state_q == StReady);
    op1_o      = d1_q;
    op2_o      = d2_q;
  end

endmodule

// File: rtl/add_reservation_station.sv
// Reservation station in front of the adder: NUM_ENT slots with fixed tags, lowest-index
// allocation, lowest-index dispatch into a registered one-cycle pulse to the adder.
module add_reservation_station
  import add_reservation_station_pkg::*;
#(
  parameter int unsigned NUM_ENT  = 3,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned TAG_W    = DefTagW,
  parameter int unsigned TAG_BASE = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  add_reservation_station_if.slave bus
);
  logic [NUM_ENT-1:0] free_vec, ready_vec, alloc_oh, disp_oh, alloc_vec, disp_vec;
  logic [DATA_W-1:0]  ent_op1 [NUM_ENT];
  logic [DATA_W-1:0]  ent_op2 [NUM_ENT];
  logic [TAG_W-1:0]   alloc_tag, sel_tag;
  logic [DATA_W-1:0]  sel_op1, sel_op2;
  logic               issue_fire, disp_fire;
  logic [2:0]         busy_cnt;

  logic               disp_valid_q;
  logic [TAG_W-1:0]   disp_tag_q;
  logic [DATA_W-1:0]  disp_op1_q, disp_op2_q;

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
    add_reservation_station_rs_entry #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .OWN_TAG (TAG_W'(TAG_BASE + i))
    ) u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_i    (alloc_vec[i]),
      .disp_i     (disp_vec[i]),
      .issue_v1_i (bus.issue_v1),
      .issue_v2_i (bus.issue_v2),
      .issue_d1_i (bus.issue_d1),
      .issue_d2_i (bus.issue_d2),
      .issue_q1_i (bus.issue_q1),
      .issue_q2_i (bus.issue_q2),
      .cdb_valid_i(bus.cdb_valid),
      .cdb_tag_i  (bus.cdb_tag),
      .cdb_data_i (bus.cdb_data),
      .is_free_o  (free_vec[i]),
      .is_ready_o (ready_vec[i]),
      .op1_o      (ent_op1[i]),
      .op2_o      (ent_op2[i])
    );
  end

  // Priority encoders: scanning downwards leaves the lowest-index hit selected.
  always_comb begin
    alloc_oh  = '0;
    alloc_tag = TAG_W'(TAG_NONE);
    disp_oh   = '0;
    sel_tag   = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    busy_cnt  = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
        alloc_tag   = TAG_W'(TAG_BASE + i);
      end
      if (ready_vec[i]) begin
        disp_oh    = '0;
        disp_oh[i] = 1'b1;
        sel_tag    = TAG_W'(TAG_BASE + i);
        sel_op1    = ent_op1[i];
        sel_op2    = ent_op2[i];
      end
      if (!free_vec[i]) busy_cnt = busy_cnt + 3'd1;
    end
  end

  assign issue_fire = bus.issue_valid && (|free_vec);
  assign disp_fire  = bus.adder_ready && (|ready_vec);
  assign alloc_vec  = alloc_oh & {NUM_ENT{issue_fire}};
  assign disp_vec   = disp_oh & {NUM_ENT{disp_fire}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid_q <= 1'b0;
      disp_tag_q   <= '0;
      disp_op1_q   <= '0;
      disp_op2_q   <= '0;
    end else begin
      disp_valid_q <= disp_fire;
      if (disp_fire) begin
        disp_tag_q <= sel_tag;
        disp_op1_q <= sel_op1;
        disp_op2_q <= sel_op2;
      end
    end
  end

  assign bus.issue_ready = |free_vec;
  assign bus.issue_tag   = alloc_tag;
  assign bus.busy_cnt    = busy_cnt;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.disp_tag    = disp_tag_q;
  assign bus.disp_op1    = disp_op1_q;
  assign bus.disp_op2    = disp_op2_q;

endmodule

// File: tb/tb_add_reservation_station.sv
// Directed bench for add_reservation_station: expected dispatches are queued at issue
// time and matched by a negedge monitor; state checks are immediate assertions.
module tb_add_reservation_station;
  typedef struct packed {
    logic [2:0] tag;
    logic [7:0] op1;
    logic [7:0] op2;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  add_reservation_station_if #(.DATA_W(8), .TAG_W(3)) bus ();

  add_reservation_station #(
    .NUM_ENT (3),
    .DATA_W  (8),
    .TAG_W   (3),
    .TAG_BASE(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] tag, input logic [7:0] op1, input logic [7:0] op2);
    exp_t e;
    e.tag = tag;
    e.op1 = op1;
    e.op2 = op2;
    exp_q.push_back(e);
  endtask

  task automatic drive_issue(input logic v1, input logic [7:0] d1, input logic [2:0] q1,
                             input logic v2, input logic [7:0] d2, input logic [2:0] q2);
    bus.issue_valid = 1'b1;
    bus.issue_v1    = v1;
    bus.issue_d1    = d1;
    bus.issue_q1    = q1;
    bus.issue_v2    = v2;
    bus.issue_d2    = d2;
    bus.issue_q2    = q2;
  endtask

  task automatic drive_cdb(input logic [2:0] tag, input logic [7:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  // Scoreboard monitor: every dispatch pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.disp_valid) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL disp_unexpected: observed dispatch tag %0d required no dispatch",
               bus.disp_tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("disp_tag", 32'(bus.disp_tag), 32'(e.tag));
        chk("disp_op1", 32'(bus.disp_op1), 32'(e.op1));
        chk("disp_op2", 32'(bus.disp_op2), 32'(e.op2));
      end
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_v1    = 1'b0;
    bus.issue_v2    = 1'b0;
    bus.issue_d1    = '0;
    bus.issue_d2    = '0;
    bus.issue_q1    = '0;
    bus.issue_q2    = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_data    = '0;
    bus.adder_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_issue_tag", 32'(bus.issue_tag), 32'd1);
    chk("rst_busy_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_disp_tag", 32'(bus.disp_tag), 32'd0);
    chk("rst_disp_op1", 32'(bus.disp_op1), 32'd0);
    chk("rst_disp_op2", 32'(bus.disp_op2), 32'd0);
    rst_n = 1'b1;

    // Both operands present: READY after the issue edge, pulse after the next edge.
    @(negedge clk);
    bus.adder_ready = 1'b1;
    drive_issue(1'b1, 8'h05, 3'd0, 1'b1, 8'h03, 3'd0);
    chk("t1_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("t1_issue_tag", 32'(bus.issue_tag), 32'd1);
    push(3'd1, 8'h05, 8'h03);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk("t1_busy_cnt", 32'(bus.busy_cnt), 32'd1);
    chk("t1_no_early_disp", 32'(bus.disp_valid), 32'd0);
    @(negedge clk);
    chk("t1_disp_valid", 32'(bus.disp_valid), 32'd1);
    drive_cdb(3'd1, 8'h08);
    @(negedge clk);
    bus.cdb_valid = 1'b0;
    chk("t1_freed", 32'(bus.busy_cnt), 32'd0);

    // Operand 1 waits on tag 5, filled later by snoop.
    drive_issue(1'b0, 8'h00, 3'd5, 1'b1, 8'h10, 3'd0);
    chk("t2_issue_tag", 32'(bus.issue_tag), 32'd1);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk("t2_busy_cnt", 32'(bus.busy_cnt), 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_waiting", 32'(bus.disp_valid), 32'd0);
    drive_cdb(3'd5, 8'h22);
    push(3'd1, 8'h22, 8'h10);
    @(negedge clk);
    bus.cdb_valid = 1'b0;
    chk("t2_not_yet", 32'(bus.disp_valid), 32'd0);
    @(negedge clk);
    chk("t2_disp_valid", 32'(bus.disp_valid), 32'd1);
    drive_cdb(3'd1, 8'h32);
    @(negedge clk);
    bus.cdb_valid = 1'b0;

    // Both operands caught by the issue-cycle bypass.
    drive_issue(1'b0, 8'h00, 3'd6, 1'b0, 8'h00, 3'd6);
    drive_cdb(3'd6, 8'h7F);
    chk("t3_issue_tag", 32'(bus.issue_tag), 32'd1);
    push(3'd1, 8'h7F, 8'h7F);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    @(negedge clk);
    chk("t3_disp_valid", 32'(bus.disp_valid), 32'd1);
    drive_cdb(3'd1, 8'hFE);
    @(negedge clk);
    bus.cdb_valid = 1'b0;

    // Fill all three entries with the adder busy.
    bus.adder_ready = 1'b0;
    drive_issue(1'b1, 8'h11, 3'd0, 1'b1, 8'h12, 3'd0);
    chk("t4_tag_a", 32'(bus.issue_tag), 32'd1);
    push(3'd1, 8'h11, 8'h12);
    @(negedge clk);
    drive_issue(1'b1, 8'h21, 3'd0, 1'b1, 8'h22, 3'd0);
    chk("t4_tag_b", 32'(bus.issue_tag), 32'd2);
    push(3'd2, 8'h21, 8'h22);
    @(negedge clk);
    drive_issue(1'b1, 8'h31, 3'd0, 1'b1, 8'h32, 3'd0);
    chk("t4_tag_c", 32'(bus.issue_tag), 32'd3);
    push(3'd3, 8'h31, 8'h32);
    @(negedge clk);
    drive_issue(1'b1, 8'h51, 3'd0, 1'b1, 8'h52, 3'd0);
    chk("t4_full_ready", 32'(bus.issue_ready), 32'd0);
    chk("t4_full_busy", 32'(bus.busy_cnt), 32'd3);
    chk("t4_no_disp", 32'(bus.disp_valid), 32'd0);
    drive_cdb(3'd2, 8'h99);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    chk("t4_not_exec_kept", 32'(bus.busy_cnt), 32'd3);
    chk("t4_still_full", 32'(bus.issue_ready), 32'd0);
    bus.adder_ready = 1'b1;

    // One dispatch, then free it while a same-cycle issue is refused.
    @(negedge clk);
    bus.adder_ready = 1'b0;
    chk("t5_disp_valid", 32'(bus.disp_valid), 32'd1);
    chk("t5_busy_exec", 32'(bus.busy_cnt), 32'd3);
    drive_cdb(3'd1, 8'h23);
    drive_issue(1'b1, 8'h41, 3'd0, 1'b1, 8'h42, 3'd0);
    chk("t5_refused", 32'(bus.issue_ready), 32'd0);
    @(negedge clk);
    bus.cdb_valid   = 1'b0;
    bus.issue_valid = 1'b0;
    chk("t5_busy_after_free", 32'(bus.busy_cnt), 32'd2);
    chk("t5_ready_after_free", 32'(bus.issue_ready), 32'd1);
    chk("t5_tag_after_free", 32'(bus.issue_tag), 32'd1);

    // Asynchronous reset with two READY entries.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("t6_disp_tag", 32'(bus.disp_tag), 32'd0);
    chk("t6_disp_op1", 32'(bus.disp_op1), 32'd0);
    chk("t6_disp_op2", 32'(bus.disp_op2), 32'd0);
    chk("t6_busy_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("t6_issue_ready", 32'(bus.issue_ready), 32'd1);
    exp_q.delete();
    bus.adder_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_disp_after_rst", 32'(bus.disp_valid), 32'd0);
      chk("t6_empty_after_rst", 32'(bus.busy_cnt), 32'd0);
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
